pipe_stage_reg: RTL and testbench

- Generic, parametrised pipeline stage register. Successor to the fixed-width per-stage IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Carries a control field and a data field between stages using a valid/ready handshake.
- A 2-entry skid buffer keeps throughput at 1 transfer/cycle under backpressure.
- Supports flush with bubble insertion and a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_sat_counter.sv | 34 +++
 rtl/pipe_stage_reg.sv | 150 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: state encoding and default NOP control.
// Latency: none (package only).
// Backpressure: not applicable.
package pipe_pkg;

  // Occupancy state of a stage register.
  localparam int unsigned PIPE_ST_W = 2;
  localparam logic [PIPE_ST_W-1:0] ST_EMPTY = 2'd0;  // nothing held
  localparam logic [PIPE_ST_W-1:0] ST_FULL  = 2'd1;  // main register valid
  localparam logic [PIPE_ST_W-1:0] ST_SKID  = 2'd2;  // main and skid both valid

  // Control value that decodes as a NOP in every downstream stage.
  localparam int unsigned CTRL_BUBBLE_DEFAULT = 0;

  // True when a state holds at least one entry that is presented downstream.
  function automatic logic st_has_entry(input logic [PIPE_ST_W-1:0] st);
    return (st != ST_EMPTY);
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear, used for stall-cycle debug counts.
// Latency: count reflects inc/clr of a cycle on the following cycle.
// Backpressure: none; sticks at all-ones instead of wrapping, clr wins over inc.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = (r_count == CNT_MAX);

  // Clear has priority; otherwise step up until the counter pins at its maximum.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && !w_at_max) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with a 2-entry skid buffer, flush and stall counter.
// Latency: 1 cycle from accept to out_valid when empty; sustains 1 transfer/cycle.
// Backpressure: a second entry lands in the skid slot; registered in_ready drops only while skid is occupied.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                CTRL_W      = 17,
  parameter int                DATA_W      = 128,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_DEFAULT),
  parameter int                CNT_W       = 16
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  // State and registered handshake.
  logic [PIPE_ST_W-1:0] r_state;
  logic [PIPE_ST_W-1:0] w_state_nxt;
  logic                 r_in_ready;

  // Main (presented) entry and skid (overflow) entry.
  logic [CTRL_W-1:0]    r_main_ctrl;
  logic [DATA_W-1:0]    r_main_data;
  logic [CTRL_W-1:0]    r_skid_ctrl;
  logic [DATA_W-1:0]    r_skid_data;

  // Datapath load enables decoded from the state transition.
  logic                 w_load_main_in;
  logic                 w_load_main_skid;
  logic                 w_load_skid;

  logic                 w_out_valid;
  logic                 w_in_acc;
  logic                 w_out_acc;
  logic                 w_stall;

  assign w_out_valid = st_has_entry(r_state);
  assign w_in_acc    = in_valid & r_in_ready;
  assign w_out_acc   = w_out_valid & out_ready;
  assign w_stall     = w_out_valid & ~out_ready;

  // Next-state and load decode; flush overrides everything and discards any offered entry.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_acc) begin
          w_load_main_in = 1'b1;
          w_state_nxt    = ST_FULL;
        end
      end
      ST_FULL: begin
        if (w_in_acc && w_out_acc) begin
          // Downstream drains main while upstream refills it: stay full.
          w_load_main_in = 1'b1;
        end else if (w_out_acc) begin
          w_state_nxt = ST_EMPTY;
        end else if (w_in_acc) begin
          // Stalled with a new entry arriving: park it in the skid slot.
          w_load_skid = 1'b1;
          w_state_nxt = ST_SKID;
        end
      end
      ST_SKID: begin
        // in_ready is low here, so only the drain side can move.
        if (w_out_acc) begin
          w_load_main_skid = 1'b1;
          w_state_nxt      = ST_FULL;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
    if (flush) begin
      w_state_nxt      = ST_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  // State register; in_ready is registered from the next state so it has no input-to-output path.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_SKID);
    end
  end

  // Main register loads from the input or promotes the skid entry; it is left stale when emptied.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_main_ctrl <= '0;
      r_main_data <= '0;
    end else if (w_load_main_in) begin
      r_main_ctrl <= in_ctrl;
      r_main_data <= in_data;
    end else if (w_load_main_skid) begin
      r_main_ctrl <= r_skid_ctrl;
      r_main_data <= r_skid_data;
    end
  end

  // Skid register captures the entry that arrives while the main entry is stalled.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else if (w_load_skid) begin
      r_skid_ctrl <= in_ctrl;
      r_skid_data <= in_data;
    end
  end

  // Stall cycles: an entry is presented but downstream refuses it (flush cycles included).
  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .sysclk (sysclk),
    .reset  (reset),
    .inc    (w_stall),
    .clr    (clr_cnt),
    .count  (stall_cnt)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  // Downstream sees a NOP control word whenever nothing valid is held.
  assign out_ctrl  = w_out_valid ? r_main_ctrl : CTRL_BUBBLE;
  assign out_data  = r_main_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: reset, streaming, skid backpressure,
// flush, stall counter saturation/clear and asynchronous reset in the middle of a stall.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_pipe_stage_reg;

  localparam int                CTRL_W = 17;
  localparam int                DATA_W = 128;
  localparam int                CNT_W  = 3;
  localparam logic [CTRL_W-1:0] BUBBLE = 17'h15A5A;

  logic              sysclk = 1'b0;
  logic              clk_en = 1'b0;
  logic              reset  = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic              clr_cnt = 1'b0;
  logic [CNT_W-1:0]  stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_reg #(
    .CTRL_W      (CTRL_W),
    .DATA_W      (DATA_W),
    .CTRL_BUBBLE (BUBBLE),
    .CNT_W       (CNT_W)
  ) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .clr_cnt   (clr_cnt),
    .stall_cnt (stall_cnt)
  );

  // Clock only runs once enabled, so reset can be checked with no edges at all.
  always #5 if (clk_en) sysclk = ~sysclk;

  // Control word carried with each test entry; never equal to BUBBLE.
  function automatic logic [CTRL_W-1:0] mkctrl(input logic [7:0] d);
    return {9'h103, d};
  endfunction

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = DATA_W'(d);
    in_ctrl  = mkctrl(d);
  endtask

  task automatic clear_counter();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #5;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_ctrl !== BUBBLE) begin n_fail++; $display("FAIL rst_out_ctrl: got %h want %h", out_ctrl, BUBBLE); end
    n_checks++; if (stall_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt); end
    n_checks++; if (out_data !== 128'h0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    clk_en = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rel_out_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_ctrl !== BUBBLE) begin n_fail++; $display("FAIL rel_out_ctrl: got %h want %h", out_ctrl, BUBBLE); end
    n_checks++; if (stall_cnt !== 3'd0) begin n_fail++; $display("FAIL rel_stall_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_stream();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, vals[i]);
      step();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid); end
      n_checks++; if (out_data !== DATA_W'(vals[i])) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", i, out_data, vals[i]); end
      n_checks++; if (out_ctrl !== mkctrl(vals[i])) begin n_fail++; $display("FAIL stream_ctrl[%0d]: got %h want %h", i, out_ctrl, mkctrl(vals[i])); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
    end
    offer(1'b0, 8'h00);
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain_valid: got %b want 0", out_valid); end
    n_checks++; if (out_ctrl !== BUBBLE) begin n_fail++; $display("FAIL stream_drain_ctrl: got %h want %h", out_ctrl, BUBBLE); end
    n_checks++; if (stall_cnt !== 3'd0) begin n_fail++; $display("FAIL stream_stall_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_backpressure();
    clear_counter();
    out_ready = 1'b1;
    offer(1'b1, 8'h0A);
    step();
    n_checks++; if (out_data !== 128'h0A) begin n_fail++; $display("FAIL bp_first: got %h want 0a", out_data); end
    out_ready = 1'b0;
    offer(1'b1, 8'h0B);
    step();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_skid_in_ready: got %b want 0", in_ready); end
    n_checks++; if (out_data !== 128'h0A) begin n_fail++; $display("FAIL bp_skid_hold: got %h want 0a", out_data); end
    // Upstream keeps offering a third entry; it must wait until in_ready returns.
    offer(1'b1, 8'h5F);
    step();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_skid_in_ready2: got %b want 0", in_ready); end
    n_checks++; if (out_data !== 128'h0A) begin n_fail++; $display("FAIL bp_skid_hold2: got %h want 0a", out_data); end
    n_checks++; if (stall_cnt !== 3'd2) begin n_fail++; $display("FAIL bp_stall_cnt: got %0d want 2", stall_cnt); end
    out_ready = 1'b1;
    step();
    n_checks++; if (out_data !== 128'h0B) begin n_fail++; $display("FAIL bp_second: got %h want 0b", out_data); end
    n_checks++; if (out_ctrl !== mkctrl(8'h0B)) begin n_fail++; $display("FAIL bp_second_ctrl: got %h want %h", out_ctrl, mkctrl(8'h0B)); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_back: got %b want 1", in_ready); end
    step();
    n_checks++; if (out_data !== 128'h5F) begin n_fail++; $display("FAIL bp_third: got %h want 5f", out_data); end
    offer(1'b0, 8'h00);
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain_valid: got %b want 0", out_valid); end
    n_checks++; if (stall_cnt !== 3'd2) begin n_fail++; $display("FAIL bp_stall_final: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_flush();
    clear_counter();
    out_ready = 1'b1;
    offer(1'b1, 8'h01);
    step();
    out_ready = 1'b0;
    offer(1'b1, 8'h02);
    step();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fl_pre_skid: got %b want 0", in_ready); end
    offer(1'b1, 8'h0C);
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid: got %b want 0", out_valid); end
    n_checks++; if (out_ctrl !== BUBBLE) begin n_fail++; $display("FAIL fl_ctrl: got %h want %h", out_ctrl, BUBBLE); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_in_ready: got %b want 1", in_ready); end
    n_checks++; if (stall_cnt !== 3'd2) begin n_fail++; $display("FAIL fl_stall_cnt: got %0d want 2", stall_cnt); end
    out_ready = 1'b1;
    offer(1'b1, 8'h0D);
    step();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fl_next_valid: got %b want 1", out_valid); end
    n_checks++; if (out_data !== 128'h0D) begin n_fail++; $display("FAIL fl_next_data: got %h want 0d", out_data); end
    offer(1'b0, 8'h00);
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_drain_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_stall_sat();
    clear_counter();
    out_ready = 1'b0;
    offer(1'b1, 8'h05);
    step();
    offer(1'b0, 8'h00);
    n_checks++; if (stall_cnt !== 3'd0) begin n_fail++; $display("FAIL sat_start: got %0d want 0", stall_cnt); end
    repeat (3) step();
    n_checks++; if (stall_cnt !== 3'd3) begin n_fail++; $display("FAIL sat_mid: got %0d want 3", stall_cnt); end
    repeat (7) step();
    n_checks++; if (stall_cnt !== 3'd7) begin n_fail++; $display("FAIL sat_top: got %0d want 7", stall_cnt); end
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    n_checks++; if (stall_cnt !== 3'd0) begin n_fail++; $display("FAIL sat_clr: got %0d want 0", stall_cnt); end
    step();
    n_checks++; if (stall_cnt !== 3'd1) begin n_fail++; $display("FAIL sat_resume1: got %0d want 1", stall_cnt); end
    step();
    n_checks++; if (stall_cnt !== 3'd2) begin n_fail++; $display("FAIL sat_resume2: got %0d want 2", stall_cnt); end
    n_checks++; if (out_data !== 128'h05) begin n_fail++; $display("FAIL sat_hold_data: got %h want 05", out_data); end
    out_ready = 1'b1;
    step();
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_drain_valid: got %b want 0", out_valid); end
    n_checks++; if (stall_cnt !== 3'd2) begin n_fail++; $display("FAIL sat_idle_hold: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_async_reset();
    clear_counter();
    out_ready = 1'b1;
    offer(1'b1, 8'h07);
    step();
    out_ready = 1'b0;
    offer(1'b1, 8'h08);
    step();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ar_pre_skid: got %b want 0", in_ready); end
    offer(1'b0, 8'h00);
    #3;
    reset = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_ctrl !== BUBBLE) begin n_fail++; $display("FAIL ar_ctrl: got %h want %h", out_ctrl, BUBBLE); end
    n_checks++; if (out_data !== 128'h0) begin n_fail++; $display("FAIL ar_data: got %h want 0", out_data); end
    n_checks++; if (stall_cnt !== 3'd0) begin n_fail++; $display("FAIL ar_stall_cnt: got %0d want 0", stall_cnt); end
    step();
    reset = 1'b1;
    out_ready = 1'b1;
    offer(1'b1, 8'h0E);
    step();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_resume_valid: got %b want 1", out_valid); end
    n_checks++; if (out_data !== 128'h0E) begin n_fail++; $display("FAIL ar_resume_data: got %h want 0e", out_data); end
    offer(1'b0, 8'h00);
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_drain_valid: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_stall_sat();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case the sequence ever stops advancing.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time %0t exceeded limit 50000", $time);
    $fatal(1);
  end

endmodule
